// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register stage with an optional second (skid) entry.
// Define PIPE_STAGE_SKID_EN for the 2-entry skid buffer with registered in_ready.
module pipe_stage_reg #(
   parameter int unsigned BUS_WIDTH  = 64,
   parameter int unsigned CTRL_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [CTRL_WIDTH-1:0] in_ctrl,
   input  logic [BUS_WIDTH-1:0]  in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [CTRL_WIDTH-1:0] out_ctrl,
   output logic [BUS_WIDTH-1:0]  out_data,
   output logic [1:0]            occupancy
);

`ifdef PIPE_STAGE_SKID_EN
   typedef enum logic [1:0] {StEmpty = 2'd0, StFull = 2'd1, StSkid = 2'd2} state_e;
`else
   typedef enum logic [1:0] {StEmpty = 2'd0, StFull = 2'd1} state_e;
`endif

   state_e                state_q, state_d;
   logic [BUS_WIDTH-1:0]  main_data_q, main_data_d;
   logic [CTRL_WIDTH-1:0] main_ctrl_q, main_ctrl_d;
   logic                  accept;
   logic                  transfer;

   assign accept    = in_valid & in_ready;
   assign transfer  = out_valid & out_ready;
   assign out_valid = (state_q != StEmpty);
   assign out_data  = main_data_q;
   // A bubble must never present a live control bit downstream.
   assign out_ctrl  = out_valid ? main_ctrl_q : '0;
   assign occupancy = 2'(state_q);

`ifdef PIPE_STAGE_SKID_EN
   logic [BUS_WIDTH-1:0]  skid_data_q, skid_data_d;
   logic [CTRL_WIDTH-1:0] skid_ctrl_q, skid_ctrl_d;
   logic                  in_ready_q, in_ready_d;

   assign in_ready = in_ready_q;

   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      main_ctrl_d = main_ctrl_q;
      skid_data_d = skid_data_q;
      skid_ctrl_d = skid_ctrl_q;
      unique case (state_q)
         StEmpty: begin
            if (accept) begin
               state_d     = StFull;
               main_data_d = in_data;
               main_ctrl_d = in_ctrl;
            end
         end
         StFull: begin
            if (transfer && accept) begin
               main_data_d = in_data;
               main_ctrl_d = in_ctrl;
            end else if (transfer) begin
               state_d = StEmpty;
            end else if (accept) begin
               state_d     = StSkid;
               skid_data_d = in_data;
               skid_ctrl_d = in_ctrl;
            end
         end
         StSkid: begin
            if (transfer) begin
               state_d     = StFull;
               main_data_d = skid_data_q;
               main_ctrl_d = skid_ctrl_q;
            end
         end
         default: state_d = StEmpty;
      endcase
      // Flush kills entries by clearing control only; payloads are left in place.
      if (flush) begin
         state_d     = StEmpty;
         main_data_d = main_data_q;
         main_ctrl_d = '0;
         skid_data_d = skid_data_q;
         skid_ctrl_d = '0;
      end
      in_ready_d = (state_d != StSkid);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         skid_data_q <= '0;
         skid_ctrl_q <= '0;
         in_ready_q  <= 1'b0;
      end else begin
         skid_data_q <= skid_data_d;
         skid_ctrl_q <= skid_ctrl_d;
         in_ready_q  <= in_ready_d;
      end
   end
`else
   logic ready_en_q;

   // Held low through reset and released on the first edge afterwards.
   assign in_ready = ready_en_q & (~out_valid | out_ready);

   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      main_ctrl_d = main_ctrl_q;
      unique case (state_q)
         StEmpty: begin
            if (accept) begin
               state_d     = StFull;
               main_data_d = in_data;
               main_ctrl_d = in_ctrl;
            end
         end
         StFull: begin
            if (transfer && accept) begin
               main_data_d = in_data;
               main_ctrl_d = in_ctrl;
            end else if (transfer) begin
               state_d = StEmpty;
            end
         end
         default: state_d = StEmpty;
      endcase
      if (flush) begin
         state_d     = StEmpty;
         main_data_d = main_data_q;
         main_ctrl_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ready_en_q <= 1'b0;
      end else begin
         ready_en_q <= 1'b1;
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StEmpty;
         main_data_q <= '0;
         main_ctrl_q <= '0;
      end else begin
         state_q     <= state_d;
         main_data_q <= main_data_d;
         main_ctrl_q <= main_ctrl_d;
      end
   end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The module SHALL have the parameter BUS_WIDTH, default 64, giving the payload (data) width in bits.
REQ-002 The module SHALL have the parameter CTRL_WIDTH, default 8, giving the control-bit vector width (reg_write, mem_write, ...).
REQ-003 The module SHALL have the port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 The module SHALL have the port rst, input, 1 bit: the reset, which is asynchronous and active-high.
REQ-005 The module SHALL have the port flush, input, 1 bit: a synchronous kill of all held entries.
REQ-006 The module SHALL have the port in_valid, input, 1 bit: the upstream entry is valid.
REQ-007 The module SHALL have the port in_ready, output, 1 bit: the stage can accept an entry this cycle.
REQ-008 The module SHALL have the port in_ctrl, input, CTRL_WIDTH bits: the upstream control bits.
REQ-009 The module SHALL have the port in_data, input, BUS_WIDTH bits: the upstream payload.
REQ-010 The module SHALL have the port out_valid, output, 1 bit: the downstream entry is valid.
REQ-011 The module SHALL have the port out_ready, input, 1 bit: downstream accepts the entry (replaces the legacy stall signal; stall == ~out_ready).
REQ-012 The module SHALL have the port out_ctrl, output, CTRL_WIDTH bits: the control bits of the head entry.
REQ-013 The module SHALL have the port out_data, output, BUS_WIDTH bits: the payload of the head entry.
REQ-014 The module SHALL have the port occupancy, output, 2 bits: the number of held entries (0..2).

Function
REQ-015 An entry SHALL be accepted on a clock edge where in_valid & in_ready, and transferred on a clock edge where out_valid & out_ready.
REQ-016 The state machine SHALL have the states EMPTY (occupancy 0), FULL (1, main register) and SKID (2, main + skid register).
REQ-017 From EMPTY: accept -> FULL, main <= in; out_valid rises exactly 1 cycle after acceptance.
REQ-018 From FULL: transfer & accept -> FULL, main <= in; transfer only -> EMPTY; accept only -> SKID, skid <= in; neither -> FULL, with main held unchanged.
REQ-019 From SKID: transfer -> FULL, main <= skid; no transfer -> SKID, with all held entries unchanged.
REQ-020 in_ready SHALL be a registered signal: 1 in EMPTY and FULL, 0 in SKID; it SHALL have no combinational path from out_ready.
REQ-021 Entries SHALL leave in acceptance order, with no loss and no duplication.
REQ-022 out_data and out_ctrl SHALL always reflect the main register; out_ctrl SHALL be forced to all-zero whenever out_valid=0, so a bubble never asserts a control bit.
REQ-023 flush=1 SHALL move the block to EMPTY on the next edge regardless of state, out_ready or in_valid; a simultaneous input is discarded.
REQ-024 During flush, the data registers SHALL keep their values and the control registers SHALL be cleared.
REQ-025 in_data and in_ctrl SHALL be ignored when in_valid=0; while out_valid=1 and out_ready=0, out_data and out_ctrl SHALL be stable.

Reset
REQ-026 Asserting rst SHALL immediately, without a clock, set the state to EMPTY, out_valid=0, out_ctrl=0, out_data=0, skid registers=0, occupancy=0 and in_ready=0.
REQ-027 On the first clock edge after rst deasserts, in_ready SHALL become 1.
REQ-028 An rst assertion mid-operation SHALL discard every held entry.

Configuration
REQ-029 The macro PIPE_STAGE_SKID_EN SHALL control the skid buffer; when it is defined, the behaviour is REQ-016..REQ-020 with a 2-entry skid.
REQ-030 When PIPE_STAGE_SKID_EN is undefined, there SHALL be no skid register or SKID state, occupancy SHALL be at most 1, and in_ready SHALL be combinational: ~out_valid | out_ready.
REQ-031 All other requirements SHALL hold in both configurations.

Verification
REQ-032 Reset, then in_valid=1 with data 0xA5 and ctrl 0x01, out_ready=1 -> the next cycle shows out_valid=1, out_data=0xA5, out_ctrl=0x01.
REQ-033 Send 0x11 then 0x22 with out_ready=0 (SKID_EN) -> occupancy=2 and in_ready=0; release out_ready -> 0x11 then 0x22 appear on consecutive cycles.
REQ-034 Stream 100 random entries with random in_valid/out_ready -> the output sequence equals the input sequence, and out_ctrl=0 on every cycle where out_valid=0.
REQ-035 Flush in SKID together with in_valid=1 (data 0x33) -> the next cycle shows EMPTY, out_valid=0, out_ctrl=0, and 0x33 never appears at the output.
REQ-036 Assert rst asynchronously between edges while FULL -> out_valid=0 and occupancy=0 before the next edge.
REQ-037 With SKID_EN undefined, out_valid=1 and out_ready toggling -> in_ready equals out_ready in the same cycle.
